tc_pl_cap_gain_sched: RTL and testbench

//  Sequencer for the registered capture-gain selector (4 gains -> cycle/Lddel mux).
//  On start, walks the enabled gains in ascending index: selects a gain, waits for the mux

---
 rtl/tc_pl_cap_gain_sched_pkg.sv | 48 ++++
 rtl/tc_pl_cap_gain_sched_if.sv | 32 +++
 rtl/tc_pl_cap_gain_sched_dly_cnt.sv | 36 +++
 rtl/tc_pl_cap_gain_sched.sv | 206 ++++++++++++++++++++
 tb/tb_tc_pl_cap_gain_sched.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tc_pl_cap_gain_sched_pkg.sv
// Shared types, constants and mask helpers for the capture-gain sequencer.
package tc_pl_cap_gain_sched_pkg;

  localparam int NUM_GAINS  = 4;
  localparam int GAIN_IDX_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEL     = 3'd1,
    ST_LOAD    = 3'd2,
    ST_DELAY   = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_NEXT    = 3'd5
  } state_t;

  typedef struct packed {
    logic                  found;
    logic [GAIN_IDX_W-1:0] idx;
  } gain_pick_t;

  // Index of the lowest set bit; 0 when the mask is empty (callers check the mask first).
  function automatic logic [GAIN_IDX_W-1:0] lowest_set(input logic [NUM_GAINS-1:0] mask);
    logic [GAIN_IDX_W-1:0] v;
    v = 2'd0;
    for (int i = NUM_GAINS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        v = GAIN_IDX_W'(i);
      end
    end
    return v;
  endfunction

  // Next set bit strictly above idx; found=0 when idx was the highest enabled gain.
  function automatic gain_pick_t next_above(input logic [NUM_GAINS-1:0] mask,
                                            input logic [GAIN_IDX_W-1:0] idx);
    gain_pick_t r;
    r.found = 1'b0;
    r.idx   = 2'd0;
    for (int i = 0; i < NUM_GAINS; i++) begin
      if (!r.found && mask[i] && (i > int'(idx))) begin
        r.found = 1'b1;
        r.idx   = GAIN_IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tc_pl_cap_gain_sched_if.sv
// Control / status bundle between the gain sequencer and its environment.
// Signal direction prefixes are from the sequencer's point of view.
interface tc_pl_cap_gain_sched_if #(
  parameter int CAP0_1  = 3,
  parameter int CAP0_10 = 18,
  parameter int CAP0_11 = 32
) ();

  logic               i_start;
  logic               i_abort;
  logic               i_cont_mode;
  logic [3:0]         i_gain_mask;
  logic [CAP0_10-1:0] i_cap_gain_cycle;
  logic [CAP0_11-1:0] i_cap_gain_Lddel;
  logic [CAP0_1-2:0]  o_gain_value;
  logic               o_gain_en;
  logic               o_cap_win;
  logic               o_busy;
  logic               o_done;
  logic               o_err;

  modport master (
    output i_start, i_abort, i_cont_mode, i_gain_mask, i_cap_gain_cycle, i_cap_gain_Lddel,
    input  o_gain_value, o_gain_en, o_cap_win, o_busy, o_done, o_err
  );

  modport slave (
    input  i_start, i_abort, i_cont_mode, i_gain_mask, i_cap_gain_cycle, i_cap_gain_Lddel,
    output o_gain_value, o_gain_en, o_cap_win, o_busy, o_done, o_err
  );

endinterface

// File: rtl/tc_pl_cap_gain_sched_dly_cnt.sv
// Loadable down-counter used for both the load-delay hold-off and the capture window.
// Stops at zero rather than wrapping; o_is_one marks the last counted cycle.
module tc_pl_cap_gain_sched_dly_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_is_one
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_one;

  assign w_one    = {{(W-1){1'b0}}, 1'b1};
  assign o_is_one = (r_cnt == w_one);

  // Counter register: clear, load, or decrement while enabled and non-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != {W{1'b0}})) begin
      r_cnt <= r_cnt - w_one;
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/tc_pl_cap_gain_sched.sv
// Capture-gain sequencer: walks the enabled gains, strobes the gain mux, waits out
// the per-gain load delay and opens a capture window of the per-gain cycle count.
module tc_pl_cap_gain_sched #(
  parameter int CAP0_1  = 3,
  parameter int CAP0_10 = 18,
  parameter int CAP0_11 = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  tc_pl_cap_gain_sched_if.slave      bus
);

  import tc_pl_cap_gain_sched_pkg::*;

  localparam int GV_W = CAP0_1 - 1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [NUM_GAINS-1:0]  r_mask;
  logic [NUM_GAINS-1:0]  w_mask_nxt;
  logic [GAIN_IDX_W-1:0] r_idx;
  logic [GAIN_IDX_W-1:0] w_idx_nxt;
  logic                  r_win_zero;
  logic                  w_win_zero_nxt;
  gain_pick_t            w_above;

  logic w_dly_load;
  logic w_dly_en;
  logic w_dly_one;
  logic w_win_load;
  logic w_win_en;
  logic w_win_one;
  logic w_cnt_clr;
  logic w_done;
  logic w_err;

  logic [GV_W-1:0] r_gain_value;
  logic [GV_W-1:0] w_gain_value_nxt;
  logic            r_gain_en;
  logic            w_gain_en_nxt;
  logic            r_cap_win;
  logic            w_cap_win_nxt;
  logic            r_busy;
  logic            w_busy_nxt;
  logic            r_err;
  logic            w_err_nxt;

  // Counters idle at zero whenever the sequencer is parked.
  assign w_cnt_clr = (r_state == ST_IDLE);

  tc_pl_cap_gain_sched_dly_cnt #(.W(CAP0_11)) u_dly_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_cnt_clr),
    .i_load     (w_dly_load),
    .i_load_val (bus.i_cap_gain_Lddel),
    .i_en       (w_dly_en),
    .o_is_one   (w_dly_one)
  );

  tc_pl_cap_gain_sched_dly_cnt #(.W(CAP0_10)) u_win_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_cnt_clr),
    .i_load     (w_win_load),
    .i_load_val (bus.i_cap_gain_cycle),
    .i_en       (w_win_en),
    .o_is_one   (w_win_one)
  );

  // State, latched mask, current gain index and zero-window flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_mask     <= 4'b0000;
      r_idx      <= 2'd0;
      r_win_zero <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mask     <= w_mask_nxt;
      r_idx      <= w_idx_nxt;
      r_win_zero <= w_win_zero_nxt;
    end
  end

  // Next-state, index walk and counter control; abort overrides everything.
  always_comb begin
    w_state_nxt    = r_state;
    w_mask_nxt     = r_mask;
    w_idx_nxt      = r_idx;
    w_win_zero_nxt = r_win_zero;
    w_dly_load     = 1'b0;
    w_win_load     = 1'b0;
    w_dly_en       = 1'b0;
    w_win_en       = 1'b0;
    w_done         = 1'b0;
    w_err          = 1'b0;
    w_above        = next_above(r_mask, r_idx);
    if (bus.i_abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_start && (bus.i_gain_mask != 4'b0000)) begin
            w_mask_nxt  = bus.i_gain_mask;
            w_idx_nxt   = lowest_set(bus.i_gain_mask);
            w_state_nxt = ST_SEL;
          end else if (bus.i_start) begin
            w_err = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_SEL: begin
          w_state_nxt = ST_LOAD;
        end
        ST_LOAD: begin
          // Mux registers were loaded on the closing edge of SEL, so they are valid here.
          w_dly_load     = 1'b1;
          w_win_load     = 1'b1;
          w_win_zero_nxt = (bus.i_cap_gain_cycle == {CAP0_10{1'b0}});
          if (bus.i_cap_gain_Lddel != {CAP0_11{1'b0}}) begin
            w_state_nxt = ST_DELAY;
          end else if (bus.i_cap_gain_cycle != {CAP0_10{1'b0}}) begin
            w_state_nxt = ST_CAPTURE;
          end else begin
            w_state_nxt = ST_NEXT;
          end
        end
        ST_DELAY: begin
          w_dly_en = 1'b1;
          if (w_dly_one && r_win_zero) begin
            w_state_nxt = ST_NEXT;
          end else if (w_dly_one) begin
            w_state_nxt = ST_CAPTURE;
          end else begin
            w_state_nxt = ST_DELAY;
          end
        end
        ST_CAPTURE: begin
          w_win_en = 1'b1;
          if (w_win_one) begin
            w_state_nxt = ST_NEXT;
          end else begin
            w_state_nxt = ST_CAPTURE;
          end
        end
        ST_NEXT: begin
          // cont_mode is deliberately read live here, not latched at start.
          if (w_above.found) begin
            w_idx_nxt   = w_above.idx;
            w_state_nxt = ST_SEL;
          end else if (bus.i_cont_mode) begin
            w_idx_nxt   = lowest_set(r_mask);
            w_state_nxt = ST_SEL;
          end else begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so registered outputs line up with it.
  always_comb begin
    w_gain_en_nxt = (w_state_nxt == ST_SEL);
    w_cap_win_nxt = (w_state_nxt == ST_CAPTURE);
    w_busy_nxt    = (w_state_nxt != ST_IDLE);
    w_err_nxt     = w_err;
    if (w_state_nxt == ST_SEL) begin
      w_gain_value_nxt = GV_W'(w_idx_nxt);
    end else begin
      w_gain_value_nxt = r_gain_value;
    end
  end

  // Output registers; gain_value holds the last selection so the mux stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gain_value <= {GV_W{1'b0}};
      r_gain_en    <= 1'b0;
      r_cap_win    <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_gain_value <= w_gain_value_nxt;
      r_gain_en    <= w_gain_en_nxt;
      r_cap_win    <= w_cap_win_nxt;
      r_busy       <= w_busy_nxt;
      r_err        <= w_err_nxt;
    end
  end

  assign bus.o_gain_value = r_gain_value;
  assign bus.o_gain_en    = r_gain_en;
  assign bus.o_cap_win    = r_cap_win;
  assign bus.o_busy       = r_busy;
  assign bus.o_err        = r_err;
  // done must appear in the NEXT cycle itself and honour the live cont_mode/abort.
  assign bus.o_done       = w_done;

endmodule

// File: tb/tb_tc_pl_cap_gain_sched.sv
// Directed bench for the capture-gain sequencer with a registered gain-mux model.
module tb_tc_pl_cap_gain_sched;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [31:0] tbl_dly [4];
  logic [17:0] tbl_cyc [4];
  logic [6:0]  w_obs;

  tc_pl_cap_gain_sched_if #(.CAP0_1(3), .CAP0_10(18), .CAP0_11(32)) bus ();

  tc_pl_cap_gain_sched #(.CAP0_1(3), .CAP0_10(18), .CAP0_11(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign w_obs = {bus.o_busy, bus.o_gain_en, bus.o_gain_value, bus.o_cap_win, bus.o_done, bus.o_err};

  always #5 clk = ~clk;

  // Registered gain mux: loads the selected gain's parameters on the gain_en edge.
  always @(posedge clk) begin
    if (bus.o_gain_en) begin
      bus.i_cap_gain_cycle <= tbl_cyc[bus.o_gain_value];
      bus.i_cap_gain_Lddel <= tbl_dly[bus.o_gain_value];
    end
  end

  function automatic logic [6:0] mk(input logic b, input logic ge, input logic [1:0] v,
                                    input logic cw, input logic dn, input logic er);
    return {b, ge, v, cw, dn, er};
  endfunction

  task automatic set_tbl(input logic [31:0] dly, input logic [17:0] cyc);
    for (int i = 0; i < 4; i++) begin
      tbl_dly[i] = dly;
      tbl_cyc[i] = cyc;
    end
  endtask

  task automatic launch(input logic [3:0] mask);
    @(posedge clk);
    #1;
    bus.i_gain_mask = mask;
    bus.i_start     = 1'b1;
  endtask

  task automatic test_reset();
    logic [6:0] exp;
    exp = mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (w_obs !== exp) begin
      n_fail++;
      $display("FAIL reset_hold obs=%b exp=%b", w_obs, exp);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (w_obs !== exp) begin
      n_fail++;
      $display("FAIL reset_release obs=%b exp=%b", w_obs, exp);
    end
  endtask

  task automatic test_two_gains();
    logic [6:0] exp;
    set_tbl(32'd2, 18'd3);
    launch(4'b0101);
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) bus.i_start = 1'b0;
      if (k == 3) begin
        bus.i_gain_mask = 4'b0010;
        bus.i_start     = 1'b1;
      end
      if (k == 4) bus.i_start = 1'b0;
      exp = mk(k <= 16, (k == 1) || (k == 9), (k >= 9) ? 2'd2 : 2'd0,
               ((k >= 5) && (k <= 7)) || ((k >= 13) && (k <= 15)), k == 16, 1'b0);
      n_checks++;
      if (w_obs !== exp) begin
        n_fail++;
        $display("FAIL two_gains k=%0d obs=%b exp=%b", k, w_obs, exp);
      end
    end
  endtask

  task automatic test_empty_mask();
    logic [6:0] exp;
    launch(4'b0000);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) bus.i_start = 1'b0;
      exp = mk(1'b0, 1'b0, 2'd2, 1'b0, 1'b0, k == 1);
      n_checks++;
      if (w_obs !== exp) begin
        n_fail++;
        $display("FAIL empty_mask k=%0d obs=%b exp=%b", k, w_obs, exp);
      end
    end
  endtask

  task automatic test_zero_counts();
    logic [6:0] exp;
    set_tbl(32'd0, 18'd0);
    launch(4'b1000);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) bus.i_start = 1'b0;
      exp = mk(k <= 3, k == 1, 2'd3, 1'b0, k == 3, 1'b0);
      n_checks++;
      if (w_obs !== exp) begin
        n_fail++;
        $display("FAIL zero_counts k=%0d obs=%b exp=%b", k, w_obs, exp);
      end
    end
  endtask

  task automatic test_cont_mode();
    logic [6:0] exp;
    int         ph;
    logic [1:0] g;
    set_tbl(32'd1, 18'd1);
    bus.i_cont_mode = 1'b1;
    launch(4'b0011);
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) bus.i_start = 1'b0;
      if (k == 22) bus.i_cont_mode = 1'b0;
      ph = (k - 1) % 5;
      g  = 2'(((k - 1) / 5) % 2);
      if (k <= 30) begin
        exp = mk(1'b1, ph == 0, g, ph == 3, k == 30, 1'b0);
      end else begin
        exp = mk(1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
      end
      n_checks++;
      if (w_obs !== exp) begin
        n_fail++;
        $display("FAIL cont_mode k=%0d obs=%b exp=%b", k, w_obs, exp);
      end
    end
  endtask

  task automatic test_abort();
    logic [6:0] exp;
    set_tbl(32'd0, 18'd100);
    launch(4'b0001);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) bus.i_start = 1'b0;
      if (k == 10) bus.i_abort = 1'b1;
      if (k == 11) bus.i_abort = 1'b0;
      if (k <= 10) begin
        exp = mk(1'b1, k == 1, 2'd0, k >= 3, 1'b0, 1'b0);
      end else begin
        exp = mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      end
      n_checks++;
      if (w_obs !== exp) begin
        n_fail++;
        $display("FAIL abort k=%0d obs=%b exp=%b", k, w_obs, exp);
      end
    end
    set_tbl(32'd0, 18'd2);
    launch(4'b0010);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) bus.i_start = 1'b0;
      exp = mk(k <= 5, k == 1, 2'd1, (k >= 3) && (k <= 4), k == 5, 1'b0);
      n_checks++;
      if (w_obs !== exp) begin
        n_fail++;
        $display("FAIL after_abort k=%0d obs=%b exp=%b", k, w_obs, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [6:0] exp;
    set_tbl(32'd50, 18'd3);
    launch(4'b0001);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) bus.i_start = 1'b0;
      if (k == 5) bus.i_start = 1'b1;
      if (k == 6) bus.i_start = 1'b0;
      exp = mk(1'b1, k == 1, 2'd0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (w_obs !== exp) begin
        n_fail++;
        $display("FAIL busy_start k=%0d obs=%b exp=%b", k, w_obs, exp);
      end
    end
    rst_n = 1'b0;
    #1;
    exp = mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (w_obs !== exp) begin
      n_fail++;
      $display("FAIL async_reset obs=%b exp=%b", w_obs, exp);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_tbl(32'd0, 18'd1);
    launch(4'b0100);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) bus.i_start = 1'b0;
      exp = mk(k <= 4, k == 1, 2'd2, k == 3, k == 4, 1'b0);
      n_checks++;
      if (w_obs !== exp) begin
        n_fail++;
        $display("FAIL after_reset k=%0d obs=%b exp=%b", k, w_obs, exp);
      end
    end
  endtask

  initial begin
    clk             = 1'b0;
    rst_n           = 1'b0;
    n_checks        = 0;
    n_fail          = 0;
    bus.i_start     = 1'b0;
    bus.i_abort     = 1'b0;
    bus.i_cont_mode = 1'b0;
    bus.i_gain_mask = 4'b0000;
    set_tbl(32'd0, 18'd0);
    test_reset();
    test_two_gains();
    test_empty_mask();
    test_zero_counts();
    test_cont_mode();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
